// File: rtl/inst_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl_pkg
// Shared constants and types for the MiniMIPS32 instruction-fetch controller:
// bus widths, the stall-vector bit that holds the IF stage, the NOP word, the
// default reset PC, and the fetch FSM state encoding.
// -----------------------------------------------------------------------------
package inst_fetch_ctrl_pkg;

   localparam int INST_ADDR_W = 32;   // instruction address bus width
   localparam int INST_W      = 32;   // instruction data bus width
   localparam int STALL_W     = 6;    // CTRL stall vector width
   localparam int STALL_IF    = 1;    // stall vector bit that holds the IF stage

   localparam logic [INST_W-1:0]      ZERO_WORD       = '0;
   localparam logic [INST_ADDR_W-1:0] INIT_PC_DEFAULT = 32'hBFC0_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // free to issue a fetch
      ST_ADDR = 2'd1,   // request raised, waiting for the address to be accepted
      ST_DATA = 2'd2,   // address accepted, waiting for read data
      ST_HOLD = 2'd3    // instruction delivered while IF stalled; outputs frozen
   } fetch_state_e;

   function automatic logic word_aligned(input logic [INST_ADDR_W-1:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
// Instruction-fetch controller between the PC register and the instruction bus.
// Issues one fetch per PC over an address/data split handshake, returns the
// instruction to IF/ID, requests a pipeline stall until the instruction arrives,
// squashes fetches made stale by a branch/CP0 redirect, and keeps a returned
// instruction visible while IF is stalled.
//
// Ports
//   cpu_clk_75M        clock, rising edge
//   cpu_rst            synchronous active-high reset
//   ce_i, pc_i         PC chip-enable and current PC
//   stall_i            CTRL stall vector (bit STALL_IF holds IF)
//   branch_flag_i      ID branch redirect
//   cp0_branch_flag_i  exception / ERET redirect
//   inst_req_o, inst_addr_o, inst_addr_ok_i   address phase
//   inst_data_ok_i, inst_rdata_i              data phase
//   inst_o, inst_pc_o, inst_valid_o, exc_adel_o   registered result to IF/ID
//   stallreq_o         combinational stall request to CTRL
// -----------------------------------------------------------------------------
module inst_fetch_ctrl
   import inst_fetch_ctrl_pkg::*;
#(
   parameter logic [INST_ADDR_W-1:0] INIT_PC = INIT_PC_DEFAULT
) (
   input  logic                   cpu_clk_75M,
   input  logic                   cpu_rst,
   input  logic                   ce_i,
   input  logic [INST_ADDR_W-1:0] pc_i,
   input  logic [STALL_W-1:0]     stall_i,
   input  logic                   branch_flag_i,
   input  logic                   cp0_branch_flag_i,
   output logic                   inst_req_o,
   output logic [INST_ADDR_W-1:0] inst_addr_o,
   input  logic                   inst_addr_ok_i,
   input  logic                   inst_data_ok_i,
   input  logic [INST_W-1:0]      inst_rdata_i,
   output logic [INST_W-1:0]      inst_o,
   output logic [INST_ADDR_W-1:0] inst_pc_o,
   output logic                   inst_valid_o,
   output logic                   exc_adel_o,
   output logic                   stallreq_o
);

   fetch_state_e             state_q, state_d;
   logic                     discard_q, discard_d;
   logic [INST_ADDR_W-1:0]   addr_q, addr_d;
   logic [INST_W-1:0]        inst_q, inst_d;
   logic [INST_ADDR_W-1:0]   inst_pc_q, inst_pc_d;
   logic                     valid_q, valid_d;
   logic                     exc_q, exc_d;

   logic redirect;
   logic if_stall;
   logic fetch_slot;
   logic issue;
   logic unaligned;
   logic deliver;

   // Only the IF bit of the stall vector matters to this stage.
   logic unused_stall;
   assign unused_stall = ^{stall_i[STALL_W-1:STALL_IF+1], stall_i[STALL_IF-1:0]};

   assign redirect   = branch_flag_i | cp0_branch_flag_i;
   assign if_stall   = stall_i[STALL_IF];
   assign fetch_slot = (state_q == ST_IDLE) & ce_i & ~if_stall;
   assign issue      = fetch_slot & word_aligned(pc_i) & ~cpu_rst;
   assign unaligned  = fetch_slot & ~word_aligned(pc_i);
   // Data is accepted only if no redirect killed it earlier or in this very cycle.
   assign deliver    = (state_q == ST_DATA) & inst_data_ok_i & ~discard_q & ~redirect;

   // Request is combinational in the issue cycle so addr_ok can land the same cycle;
   // afterwards the captured address keeps the bus request stable.
   assign inst_req_o  = ~cpu_rst & (issue | (state_q == ST_ADDR));
   assign inst_addr_o = issue ? pc_i : addr_q;

   // The PC may advance only in the cycle an instruction is actually delivered,
   // or when an unaligned PC is being turned into an exception NOP.
   assign stallreq_o  = ce_i & ~deliver & ~unaligned;

   assign inst_o       = inst_q;
   assign inst_pc_o    = inst_pc_q;
   assign inst_valid_o = valid_q;
   assign exc_adel_o   = exc_q;

   always_comb begin
      state_d   = state_q;
      discard_d = discard_q;
      addr_d    = addr_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      valid_d   = 1'b0;
      exc_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (issue) begin
               addr_d  = pc_i;
               state_d = inst_addr_ok_i ? ST_DATA : ST_ADDR;
            end else if (unaligned) begin
               // No bus access: hand IF/ID a NOP flagged with an address error.
               inst_d    = ZERO_WORD;
               inst_pc_d = pc_i;
               valid_d   = 1'b1;
               exc_d     = 1'b1;
            end
         end

         ST_ADDR: begin
            if (redirect) discard_d = 1'b1;
            if (inst_addr_ok_i) state_d = ST_DATA;
         end

         ST_DATA: begin
            if (inst_data_ok_i) begin
               if (deliver) begin
                  inst_d    = inst_rdata_i;
                  inst_pc_d = addr_q;
                  valid_d   = 1'b1;
                  state_d   = if_stall ? ST_HOLD : ST_IDLE;
               end else begin
                  discard_d = 1'b0;
                  state_d   = ST_IDLE;
               end
            end else if (redirect) begin
               discard_d = 1'b1;
            end
         end

         ST_HOLD: begin
            if (cp0_branch_flag_i) begin
               state_d = ST_IDLE;
            end else if (!if_stall) begin
               // IF/ID captures the held instruction on this edge.
               state_d = ST_IDLE;
            end else begin
               valid_d = valid_q;
               exc_d   = exc_q;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge cpu_clk_75M) begin
      if (cpu_rst) begin
         state_q   <= ST_IDLE;
         discard_q <= 1'b0;
         addr_q    <= '0;
         inst_q    <= ZERO_WORD;
         inst_pc_q <= INIT_PC;
         valid_q   <= 1'b0;
         exc_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         discard_q <= discard_d;
         addr_q    <= addr_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         valid_q   <= valid_d;
         exc_q     <= exc_d;
      end
   end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_ctrl
// Directed scenarios with literal expectations, followed by randomized
// stimulus, all checked every cycle against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

   localparam logic [31:0] INIT = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        cpu_rst;
   logic        ce_i;
   logic [31:0] pc_i;
   logic [5:0]  stall_i;
   logic        branch_flag_i;
   logic        cp0_branch_flag_i;
   logic        inst_req_o;
   logic [31:0] inst_addr_o;
   logic        inst_addr_ok_i;
   logic        inst_data_ok_i;
   logic [31:0] inst_rdata_i;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        inst_valid_o;
   logic        exc_adel_o;
   logic        stallreq_o;

   always #5 clk = ~clk;

   inst_fetch_ctrl #(.INIT_PC(INIT)) dut (
      .cpu_clk_75M       (clk),
      .cpu_rst           (cpu_rst),
      .ce_i              (ce_i),
      .pc_i              (pc_i),
      .stall_i           (stall_i),
      .branch_flag_i     (branch_flag_i),
      .cp0_branch_flag_i (cp0_branch_flag_i),
      .inst_req_o        (inst_req_o),
      .inst_addr_o       (inst_addr_o),
      .inst_addr_ok_i    (inst_addr_ok_i),
      .inst_data_ok_i    (inst_data_ok_i),
      .inst_rdata_i      (inst_rdata_i),
      .inst_o            (inst_o),
      .inst_pc_o         (inst_pc_o),
      .inst_valid_o      (inst_valid_o),
      .exc_adel_o        (exc_adel_o),
      .stallreq_o        (stallreq_o)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Transaction-level model: a pending (not yet accepted) request, a queue of
   // accepted fetches awaiting data (each may be marked squashed), and a flag
   // for an instruction held while IF is stalled.
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [31:0] addr;
      bit          squash;
   } txn_t;

   bit          m_ready = 1'b0;
   bit          m_pend;
   bit          m_pend_squash;
   logic [31:0] m_req_addr;
   txn_t        m_out[$];
   bit          m_hold;
   logic [31:0] m_inst, m_pc;
   bit          m_valid, m_exc;

   function automatic bit m_idle();
      return !m_pend && (m_out.size() == 0) && !m_hold;
   endfunction

   task automatic model_step();
      bit   redir;
      bit   go;
      txn_t t;
      redir = branch_flag_i | cp0_branch_flag_i;
      go    = m_idle() && ce_i && !stall_i[1];
      if (cpu_rst) begin
         m_ready = 1'b1;
         m_pend = 0; m_pend_squash = 0; m_req_addr = '0;
         m_out.delete();
         m_hold = 0;
         m_inst = 32'h0; m_pc = INIT; m_valid = 0; m_exc = 0;
      end else if (m_ready) begin
         if (m_hold) begin
            if (cp0_branch_flag_i || !stall_i[1]) begin
               m_hold = 0; m_valid = 0; m_exc = 0;
            end
         end else begin
            m_valid = 0;
            m_exc   = 0;
            if (m_pend) begin
               if (redir) m_pend_squash = 1;
               if (inst_addr_ok_i) begin
                  t.addr = m_req_addr; t.squash = m_pend_squash;
                  m_out.push_back(t);
                  m_pend = 0;
               end
            end else if (m_out.size() != 0) begin
               if (inst_data_ok_i) begin
                  t = m_out.pop_front();
                  if (!t.squash && !redir) begin
                     m_inst = inst_rdata_i; m_pc = t.addr; m_valid = 1;
                     if (stall_i[1]) m_hold = 1;
                  end
               end else if (redir) begin
                  m_out[0].squash = 1'b1;
               end
            end else if (go) begin
               if (pc_i[1:0] == 2'b00) begin
                  if (inst_addr_ok_i) begin
                     t.addr = pc_i; t.squash = 0;
                     m_out.push_back(t);
                  end else begin
                     m_pend = 1; m_pend_squash = 0; m_req_addr = pc_i;
                  end
               end else begin
                  m_inst = 32'h0; m_pc = pc_i; m_valid = 1; m_exc = 1;
               end
            end
         end
         if (m_out.size() > 1) chk("model_outstanding", m_out.size(), 1);
      end
   endtask

   // Single compare process: outputs are sampled mid-cycle, then the model
   // advances using the inputs that the coming rising edge will see.
   always @(negedge clk) begin
      bit          go, deliv, exp_req, exp_stall;
      if (m_ready) begin
         chk("inst_valid_o", inst_valid_o, m_valid);
         chk("exc_adel_o",   exc_adel_o,   m_exc);
         if (m_valid) begin
            chk("inst_o",    inst_o,    m_inst);
            chk("inst_pc_o", inst_pc_o, m_pc);
         end
         if (!cpu_rst) begin
            go        = m_idle() && ce_i && !stall_i[1];
            exp_req   = m_pend || (go && pc_i[1:0] == 2'b00);
            deliv     = (m_out.size() != 0) && inst_data_ok_i && !m_out[0].squash
                        && !(branch_flag_i | cp0_branch_flag_i);
            exp_stall = ce_i && !deliv && !(go && pc_i[1:0] != 2'b00);
            chk("inst_req_o", inst_req_o, exp_req);
            if (exp_req) chk("inst_addr_o", inst_addr_o, m_pend ? m_req_addr : pc_i);
            chk("stallreq_o", stallreq_o, exp_stall);
         end
      end
      model_step();
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      ce_i = 0; stall_i = '0; branch_flag_i = 0; cp0_branch_flag_i = 0;
      inst_addr_ok_i = 0; inst_data_ok_i = 0; inst_rdata_i = '0;
   endtask

   initial begin
      cpu_rst = 1; pc_i = INIT; quiet();
      tick(); tick();
      cpu_rst = 0;

      // Reset state
      @(negedge clk);
      chk("rst_req", inst_req_o, 0);        chk("rst_addr", inst_addr_o, 0);
      chk("rst_stallreq", stallreq_o, 0);   chk("rst_valid", inst_valid_o, 0);
      chk("rst_pc", inst_pc_o, INIT);       chk("rst_inst", inst_o, 0);
      chk("rst_exc", exc_adel_o, 0);
      tick();

      // Basic fetch: addr_ok same cycle, data_ok next
      ce_i = 1; pc_i = INIT; inst_addr_ok_i = 1;
      @(negedge clk);
      chk("basic_req", inst_req_o, 1); chk("basic_addr", inst_addr_o, INIT);
      chk("basic_stallreq_issue", stallreq_o, 1);
      tick();
      inst_addr_ok_i = 0; inst_data_ok_i = 1; inst_rdata_i = 32'h2401_0001;
      @(negedge clk); chk("basic_stallreq_dok", stallreq_o, 0);
      tick();
      quiet();
      @(negedge clk);
      chk("basic_valid", inst_valid_o, 1); chk("basic_inst", inst_o, 32'h2401_0001);
      chk("basic_pc", inst_pc_o, INIT);
      tick();
      @(negedge clk); chk("basic_valid_drop", inst_valid_o, 0);
      tick();

      // Address backpressure: addr_ok delayed 3 cycles
      ce_i = 1; pc_i = 32'hBFC0_0004;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) pc_i = 32'h1111_0000 + 32'(i * 4);
         inst_addr_ok_i = (i == 3);
         @(negedge clk);
         chk("bp_req", inst_req_o, 1); chk("bp_addr", inst_addr_o, 32'hBFC0_0004);
         chk("bp_stallreq", stallreq_o, 1);
         tick();
      end
      inst_addr_ok_i = 0; inst_data_ok_i = 1; inst_rdata_i = 32'h8C22_0000;
      tick();
      quiet();
      @(negedge clk);
      chk("bp_inst", inst_o, 32'h8C22_0000); chk("bp_pc", inst_pc_o, 32'hBFC0_0004);
      tick();

      // Branch squash while in DATA
      ce_i = 1; pc_i = 32'hBFC0_0008; inst_addr_ok_i = 1;
      tick();
      inst_addr_ok_i = 0; branch_flag_i = 1; pc_i = 32'hBFC0_0100;
      tick();
      branch_flag_i = 0; inst_data_ok_i = 1; inst_rdata_i = 32'hDEAD_BEEF;
      @(negedge clk); chk("sq_stallreq", stallreq_o, 1);
      tick();
      inst_data_ok_i = 0; inst_addr_ok_i = 1;
      @(negedge clk);
      chk("sq_valid", inst_valid_o, 0); chk("sq_req", inst_req_o, 1);
      chk("sq_addr", inst_addr_o, 32'hBFC0_0100);
      tick();
      inst_addr_ok_i = 0; inst_data_ok_i = 1; inst_rdata_i = 32'h3C1D_BFC0;
      tick();
      quiet();
      @(negedge clk);
      chk("sq_inst", inst_o, 32'h3C1D_BFC0); chk("sq_pc", inst_pc_o, 32'hBFC0_0100);
      tick();

      // IF stall when data arrives
      ce_i = 1; pc_i = 32'hBFC0_0104; inst_addr_ok_i = 1;
      tick();
      inst_addr_ok_i = 0; inst_data_ok_i = 1; inst_rdata_i = 32'h27BD_FFF0; stall_i = 6'b000010;
      tick();
      inst_data_ok_i = 0; pc_i = 32'hBFC0_0108;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("st_req", inst_req_o, 0); chk("st_valid", inst_valid_o, 1);
         chk("st_inst", inst_o, 32'h27BD_FFF0);
         tick();
      end
      stall_i = '0;
      @(negedge clk); chk("st_rel_req", inst_req_o, 0);
      tick();
      inst_addr_ok_i = 1;
      @(negedge clk);
      chk("st_new_req", inst_req_o, 1); chk("st_new_addr", inst_addr_o, 32'hBFC0_0108);
      tick();
      inst_addr_ok_i = 0; inst_data_ok_i = 1; inst_rdata_i = 32'h1111_1111;
      tick();
      quiet();
      tick();

      // Unaligned PC
      ce_i = 1; pc_i = 32'hBFC0_0002;
      @(negedge clk);
      chk("ua_req", inst_req_o, 0); chk("ua_stallreq", stallreq_o, 0);
      tick();
      quiet();
      @(negedge clk);
      chk("ua_inst", inst_o, 0); chk("ua_exc", exc_adel_o, 1);
      chk("ua_valid", inst_valid_o, 1); chk("ua_pc", inst_pc_o, 32'hBFC0_0002);
      tick();

      // Reset while in DATA, then a late data_ok
      ce_i = 1; pc_i = 32'hBFC0_0200; inst_addr_ok_i = 1;
      tick();
      inst_addr_ok_i = 0; cpu_rst = 1;
      tick();
      cpu_rst = 0; ce_i = 0; inst_data_ok_i = 1; inst_rdata_i = 32'hCAFE_F00D;
      @(negedge clk);
      chk("rd_valid", inst_valid_o, 0); chk("rd_pc", inst_pc_o, INIT);
      chk("rd_inst", inst_o, 0); chk("rd_req", inst_req_o, 0);
      tick();
      inst_data_ok_i = 0;
      @(negedge clk);
      chk("rd_valid2", inst_valid_o, 0); chk("rd_inst2", inst_o, 0);
      tick();

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         cpu_rst           = ($urandom_range(0, 299) == 0);
         ce_i              = ($urandom_range(0, 9) != 0);
         stall_i           = 6'($urandom);
         stall_i[1]        = ($urandom_range(0, 3) == 0);
         pc_i              = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'({$urandom_range(0, 255), 2'b00});
         if ($urandom_range(0, 7) == 0) pc_i[1:0] = 2'($urandom_range(1, 3));
         branch_flag_i     = ($urandom_range(0, 9) == 0);
         cp0_branch_flag_i = ($urandom_range(0, 19) == 0);
         inst_addr_ok_i    = $urandom_range(0, 1) == 1;
         inst_data_ok_i    = $urandom_range(0, 1) == 1;
         inst_rdata_i      = $urandom;
         tick();
      end

      quiet();
      cpu_rst = 0;
      tick();
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
